// File: rtl/wb_design_ctrl_pkg.sv
// wb_design_ctrl_pkg: register map, bit indices, bus FSM states and byte-lane merge helper
package wb_design_ctrl_pkg;
    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_SCRATCH  = 8'h08;
    localparam logic [7:0] OFF_TIMER    = 8'h0C;
    localparam logic [7:0] OFF_COMPARE  = 8'h10;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h14;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h18;
    localparam int CTRL_SRC  = 4;
    localparam int CTRL_FRST = 5;
    localparam int CTRL_TEN  = 6;
    localparam int ST_PEND   = 8;
    localparam int ST_RST    = 9;
    typedef enum logic {S_IDLE, S_ACK} wb_state_e;
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sel[i] ? wdat[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/wb_ctrl_timer.sv
// wb_ctrl_timer: free-running compare timer with sticky pending flag
module wb_ctrl_timer #(
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        timer_we,
    input  logic [31:0] timer_wdat,
    input  logic        compare_we,
    input  logic [31:0] compare_wdat,
    input  logic        pend_clr,
    output logic [31:0] timer,
    output logic [31:0] compare,
    output logic        pending
);
    logic match;
    // a bus load of TIMER suppresses the match for that cycle; a new match beats W1C
    assign match = en && !timer_we && timer == compare;
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            compare <= CMP_RESET;
            pending <= 1'b0;
        end else begin
            timer   <= timer_we ? timer_wdat : match ? '0 : en ? timer + 32'd1 : timer;
            compare <= compare_we ? compare_wdat : compare;
            pending <= match | (pending & ~pend_clr);
        end
    end
endmodule

// File: rtl/wb_design_ctrl.sv
// wb_design_ctrl: Wishbone classic slave for design select, soft reset pulse, scratch and timer irq
module wb_design_ctrl
    import wb_design_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          RST_PULSE = 4,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  pin_design_select,
    output logic [3:0]  design_select_o,
    output logic        design_rst_o,
    output logic        irq_o
);
    localparam logic [3:0] PULSE = 4'(RST_PULSE);
    wb_state_e state, state_nxt;
    logic [6:0] ctrl;
    logic [31:0] scratch, timer, compare, rdata;
    logic [3:0] pin_s1, pin_s2, eff_sel, rst_cnt;
    logic [7:0] off;
    logic irq_en, pending, acc, wr, rd, unused_adr;
    assign off = {wbs_adr_i[7:2], 2'b00};
    assign unused_adr = ^wbs_adr_i[1:0];
    assign acc = state == S_IDLE && wbs_cyc_i && wbs_stb_i && wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign wr = acc && wbs_we_i;
    assign rd = acc && !wbs_we_i;
    assign wbs_ack_o = state == S_ACK;
    assign eff_sel = ctrl[CTRL_SRC] ? ctrl[3:0] : pin_s2;
    assign design_rst_o = ctrl[CTRL_FRST] | (rst_cnt != 4'd0);
    always_comb state_nxt = acc ? S_ACK : S_IDLE;
    always_ff @(posedge wb_clk_i) state <= wb_rst_i ? S_IDLE : state_nxt;
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = {25'd0, ctrl};
            OFF_STATUS:   rdata = {22'd0, design_rst_o, pending, pin_design_select, design_select_o};
            OFF_SCRATCH:  rdata = scratch;
            OFF_TIMER:    rdata = timer;
            OFF_COMPARE:  rdata = compare;
            OFF_IRQ_STAT: rdata = {31'd0, pending};
            OFF_IRQ_EN:   rdata = {31'd0, irq_en};
            default:      rdata = '0;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl      <= '0;
            scratch   <= '0;
            irq_en    <= 1'b0;
            wbs_dat_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            wbs_dat_o <= rd ? rdata : '0;
            irq_o     <= pending & irq_en;
            ctrl      <= wr && off == OFF_CTRL && wbs_sel_i[0] ? wbs_dat_i[6:0] : ctrl;
            scratch   <= wr && off == OFF_SCRATCH ? byte_merge(scratch, wbs_dat_i, wbs_sel_i) : scratch;
            irq_en    <= wr && off == OFF_IRQ_EN && wbs_sel_i[0] ? wbs_dat_i[0] : irq_en;
        end
    end
    // pins pass a two-flop synchroniser; any change of the effective select restarts the reset pulse
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pin_s1          <= '0;
            pin_s2          <= '0;
            design_select_o <= '0;
            rst_cnt         <= '0;
        end else begin
            pin_s1          <= pin_design_select;
            pin_s2          <= pin_s1;
            design_select_o <= eff_sel;
            rst_cnt         <= eff_sel != design_select_o ? PULSE : rst_cnt != 4'd0 ? rst_cnt - 4'd1 : rst_cnt;
        end
    end
    wb_ctrl_timer #(.CMP_RESET(CMP_RESET)) u_timer (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .en           (ctrl[CTRL_TEN]),
        .timer_we     (wr && off == OFF_TIMER),
        .timer_wdat   (byte_merge(timer, wbs_dat_i, wbs_sel_i)),
        .compare_we   (wr && off == OFF_COMPARE),
        .compare_wdat (byte_merge(compare, wbs_dat_i, wbs_sel_i)),
        .pend_clr     (wr && off == OFF_IRQ_STAT && wbs_sel_i[0] && wbs_dat_i[0]),
        .timer        (timer),
        .compare      (compare),
        .pending      (pending)
    );
endmodule

// File: tb/tb_wb_design_ctrl.sv
// tb_wb_design_ctrl: scoreboard bench with a behavioural model of the register block
module tb_wb_design_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam longint PULSE = 4;
    logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'h0, pins = 4'h3;
    logic [31:0] adr = '0, dat_i = '0;
    logic ack, drst, irq;
    logic [31:0] dat_o, last_rd;
    logic [3:0] dsel;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;

    wb_design_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .pin_design_select(pins), .design_select_o(dsel), .design_rst_o(drst), .irq_o(irq)
    );

    typedef struct { bit rd; logic [31:0] d; } exp_t;
    exp_t exp_q[$];

    // model state: register contents plus the edge index of the last select change
    logic [6:0] m_ctrl;
    logic [31:0] m_scr, m_tmr, m_cmp;
    logic m_pend, m_ien, m_irq, m_busy, m_on = 1'b0;
    logic [3:0] m_p1, m_p2, m_sel;
    longint m_edge = 0, m_chg = -1000;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic m_rst_now();
        return m_ctrl[5] || (m_edge - m_chg < PULSE);
    endfunction

    function automatic logic [31:0] readval(input logic [7:0] o, input logic rv);
        case (o)
            8'h00: return {25'd0, m_ctrl};
            8'h04: return {22'd0, rv, m_pend, pins, m_sel};
            8'h08: return m_scr;
            8'h0C: return m_tmr;
            8'h10: return m_cmp;
            8'h14: return {31'd0, m_pend};
            8'h18: return {31'd0, m_ien};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [6:0] o_ctrl;
        logic [31:0] o_tmr, o_cmp, t_val;
        logic o_pend, o_ien, o_rst, t_we, clr, set;
        logic [3:0] eff;
        logic [7:0] o;
        o_ctrl = m_ctrl; o_tmr = m_tmr; o_cmp = m_cmp; o_pend = m_pend; o_ien = m_ien;
        o_rst = m_rst_now();
        m_edge++;
        if (rst) begin
            m_ctrl = '0; m_scr = '0; m_tmr = '0; m_cmp = 32'hFFFF_FFFF; m_pend = 0; m_ien = 0;
            m_irq = 0; m_busy = 0; m_p1 = '0; m_p2 = '0; m_sel = '0; m_chg = -1000; m_on = 1;
            exp_q.delete();
        end else begin
            t_we = 0; t_val = '0; clr = 0; set = 0;
            eff = o_ctrl[4] ? o_ctrl[3:0] : m_p2;
            if (m_busy) m_busy = 0;
            else if (cyc && stb && adr[31:8] == BASE[31:8]) begin
                m_busy = 1;
                o = {adr[7:2], 2'b00};
                if (!we) exp_q.push_back('{1'b1, readval(o, o_rst)});
                else begin
                    exp_q.push_back('{1'b0, 32'd0});
                    case (o)
                        8'h00: if (sel[0]) m_ctrl = dat_i[6:0];
                        8'h08: m_scr = merge(m_scr, dat_i, sel);
                        8'h0C: begin t_we = 1; t_val = merge(o_tmr, dat_i, sel); end
                        8'h10: m_cmp = merge(o_cmp, dat_i, sel);
                        8'h14: clr = sel[0] & dat_i[0];
                        8'h18: if (sel[0]) m_ien = dat_i[0];
                        default: ;
                    endcase
                end
            end
            if (t_we) m_tmr = t_val;
            else if (o_ctrl[6]) begin
                if (o_tmr == o_cmp) begin m_tmr = 0; set = 1; end
                else m_tmr = o_tmr + 1;
            end
            m_pend = set | (o_pend & !clr);
            m_irq = o_pend & o_ien;
            m_p2 = m_p1;
            m_p1 = pins;
            if (eff != m_sel) begin m_sel = eff; m_chg = m_edge; end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            exp_t e;
            chk("ack", ack, m_busy);
            if (ack && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.rd) chk("rdata", dat_o, e.d);
            end else if (!ack) chk("dat_idle", dat_o, 32'd0);
            chk("dsel", dsel, m_sel);
            chk("drst", drst, m_rst_now());
            chk("irq", irq, m_irq);
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cyc = 1; stb = 1; adr = a; we = w; dat_i = d; sel = s;
        do begin @(negedge clk); n++; end while (!ack && n < 20);
        last_rd = dat_o;
        chk("latency", n, 1);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
    endtask

    initial begin
        int cnt, k;
        logic [4:0] pat;
        repeat (3) @(negedge clk);
        rst = 0;
        xfer(BASE | 32'h10, 0, 0, 4'hF); chk("compare_reset", last_rd, 32'hFFFF_FFFF);
        xfer(BASE, 0, 0, 4'hF);          chk("ctrl_reset", last_rd, 32'd0);
        xfer(BASE | 32'h08, 1, 32'hA5A5_A5A5, 4'b0101);
        xfer(BASE | 32'h08, 0, 0, 4'hF); chk("scratch_sel", last_rd, 32'h00A5_00A5);
        xfer(BASE | 32'h40, 0, 0, 4'hF); chk("unmapped", last_rd, 32'd0);
        cyc = 1; stb = 1; adr = 32'h3100_0000; cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(ack); end
        chk("oow_noack", cnt, 0);
        cyc = 0; stb = 0;
        @(negedge clk);
        xfer(BASE, 1, 32'h15, 4'hF);
        chk("sel_reg", dsel, 4'h5);
        cnt = int'(drst);
        repeat (7) begin @(negedge clk); cnt += int'(drst); end
        chk("pulse_len", cnt, 4);
        xfer(BASE | 32'h04, 0, 0, 4'hF); chk("status_pins", last_rd[7:4], 4'h3);
        xfer(BASE, 1, 32'h0, 4'hF);
        repeat (10) @(negedge clk);
        pins = 4'h7; cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            cnt += int'(drst);
            if (i == 3) chk("pin_sync", dsel, 4'h7);
            if (i == 3) pins = 4'h4;
        end
        chk("pulse_ext", cnt, 7);
        chk("pin_final", dsel, 4'h4);
        xfer(BASE | 32'h10, 1, 32'd9, 4'hF);
        xfer(BASE | 32'h18, 1, 32'd1, 4'hF);
        xfer(BASE | 32'h0C, 1, 32'd0, 4'hF);
        xfer(BASE, 1, 32'h40, 4'hF);
        repeat (4) xfer(BASE | 32'h0C, 0, 0, 4'hF);
        k = 0;
        while (m_tmr != 32'd9 && k < 100) begin @(negedge clk); k++; end
        xfer(BASE | 32'h14, 1, 32'd1, 4'hF);
        xfer(BASE | 32'h14, 0, 0, 4'hF); chk("w1c_set_wins", last_rd, 32'd1);
        xfer(BASE | 32'h14, 1, 32'd1, 4'hF);
        xfer(BASE | 32'h14, 0, 0, 4'hF); chk("w1c_clear", last_rd, 32'd0);
        repeat (150) begin
            logic [7:0] o;
            o = $urandom_range(0, 7) == 0 ? 8'h40 : 8'($urandom_range(0, 6) * 4);
            if ($urandom_range(0, 3) == 0) pins = 4'($urandom);
            xfer(BASE | {24'd0, o} | 32'($urandom_range(0, 3)), 1'($urandom), $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h08; pat = '0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); pat = {pat[3:0], ack}; end
        chk("held_gap", pat, 5'b10101);
        cyc = 0; stb = 0;
        @(negedge clk);
        cyc = 1; stb = 1; adr = BASE | 32'h0C;
        @(negedge clk);
        chk("ack_before_rst", ack, 1'b1);
        rst = 1; cyc = 0; stb = 0;
        @(negedge clk);
        chk("ack_after_rst", ack, 1'b0);
        rst = 0;
        @(negedge clk);
        xfer(BASE | 32'h08, 0, 0, 4'hF); chk("scratch_rst", last_rd, 32'd0);
        xfer(BASE | 32'h10, 0, 0, 4'hF); chk("compare_rst", last_rd, 32'hFFFF_FFFF);
        xfer(BASE, 0, 0, 4'hF);          chk("ctrl_rst", last_rd, 32'd0);
        xfer(BASE | 32'h18, 0, 0, 4'hF); chk("irqen_rst", last_rd, 32'd0);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
